// File: rtl/conv_layer_scheduler_if.sv
// rtl/conv_layer_scheduler_if.sv - start/done, loader, conv-engine and result-file handshakes of the layer scheduler
interface conv_layer_scheduler_if #(
  parameter int OCW = 4,
  parameter int ICW = 3
);
  logic           start;
  logic           abort;
  logic           load_ack;
  logic           conv_done;
  logic           relu_done;
  logic           load_req;
  logic           conv_go;
  logic           relu_go;
  logic           first_write;
  logic [OCW-1:0] out_c;
  logic [ICW-1:0] in_c;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    input  start, abort, load_ack, conv_done, relu_done,
    output load_req, conv_go, relu_go, first_write, out_c, in_c, busy, done, err
  );

  modport slave (
    output start, abort, load_ack, conv_done, relu_done,
    input  load_req, conv_go, relu_go, first_write, out_c, in_c, busy, done, err
  );
endinterface

// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - walks output x input channels issuing load, conv and ReLU/writeback passes
module conv_layer_scheduler #(
  parameter int OC_COUNT = 8,
  parameter int IC_COUNT = 1,
  parameter int TIMEOUT  = 1024,
  parameter int OCW      = 4,
  parameter int ICW      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_layer_scheduler_if.master bus
);
  localparam int             WDW     = $clog2(TIMEOUT + 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(OC_COUNT - 1);
  localparam logic [ICW-1:0] IC_LAST = ICW'(IC_COUNT - 1);
  // The incremented count reaching TIMEOUT-1 trips the watchdog; assumes TIMEOUT >= 2.
  localparam logic [WDW-1:0] WD_TRIP = WDW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV_START,
    S_CONV_WAIT,
    S_RELU_START,
    S_RELU_WAIT,
    S_FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [OCW-1:0] out_c_q, out_c_d;
  logic [ICW-1:0] in_c_q, in_c_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           load_req_q, load_req_d;
  logic           conv_go_q, conv_go_d;
  logic           relu_go_q, relu_go_d;
  logic           first_write_q, first_write_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    out_c_d = out_c_q;
    in_c_d  = in_c_q;
    wd_d    = wd_q;
    err_d   = err_q;
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_LOAD;
            out_c_d = '0;
            in_c_d  = '0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.load_ack) state_d = S_CONV_START;
        end
        S_CONV_START: begin
          wd_d    = '0;
          state_d = S_CONV_WAIT;
        end
        S_CONV_WAIT: begin
          wd_d = wd_q + 1'b1;
          // A conv_done landing on the watchdog's last cycle still counts as success.
          if (bus.conv_done) begin
            if (in_c_q == IC_LAST) begin
              state_d = S_RELU_START;
            end else begin
              in_c_d  = in_c_q + 1'b1;
              state_d = S_LOAD;
            end
          end else if (wd_q == WD_TRIP) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_RELU_START: begin
          state_d = S_RELU_WAIT;
        end
        S_RELU_WAIT: begin
          if (bus.relu_done) begin
            if (out_c_q == OC_LAST) begin
              state_d = S_FINISH;
            end else begin
              out_c_d = out_c_q + 1'b1;
              in_c_d  = '0;
              state_d = S_LOAD;
            end
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so each register lines up with the state it describes.
  always_comb begin
    load_req_d    = (state_d == S_LOAD);
    conv_go_d     = (state_d == S_CONV_START);
    relu_go_d     = (state_d == S_RELU_START);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FINISH);
    first_write_d = (in_c_d == '0) &&
                    (state_d == S_LOAD || state_d == S_CONV_START || state_d == S_CONV_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      out_c_q       <= '0;
      in_c_q        <= '0;
      wd_q          <= '0;
      err_q         <= 1'b0;
      load_req_q    <= 1'b0;
      conv_go_q     <= 1'b0;
      relu_go_q     <= 1'b0;
      first_write_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_c_q       <= out_c_d;
      in_c_q        <= in_c_d;
      wd_q          <= wd_d;
      err_q         <= err_d;
      load_req_q    <= load_req_d;
      conv_go_q     <= conv_go_d;
      relu_go_q     <= relu_go_d;
      first_write_q <= first_write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.load_req    = load_req_q;
  assign bus.conv_go     = conv_go_q;
  assign bus.relu_go     = relu_go_q;
  assign bus.first_write = first_write_q;
  assign bus.out_c       = out_c_q;
  assign bus.in_c        = in_c_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule
